// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies Length words from SrcAddr to DstAddr over a
// single-port data memory. Each word is read in one cycle and written in the next.
// Ports:
//   Clk, Reset (async, active-low)
//   Start, SrcAddr, DstAddr, Length        : copy request, sampled only in IDLE
//   Busy, Done                             : status (Done is a one-cycle pulse)
//   MemAddr, MemWriteEn, MemToReg, MemWrData : memory drive (registered)
//   MemRdData                              : combinational read data for MemAddr
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Length,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWriteEn,
  output logic              MemToReg,
  output logic [DATA_W-1:0] MemWrData,
  input  logic [DATA_W-1:0] MemRdData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] src, src_d;
  logic [ADDR_W-1:0] dst, dst_d;
  logic [ADDR_W-1:0] len, len_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic [ADDR_W-1:0] idx_inc;
  logic [DATA_W-1:0] hold, hold_d;

  logic              busy_d, done_d, we_d, to_reg_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // idx never exceeds Length-1, so the increment cannot overflow ADDR_W bits
  assign idx_inc = ADDR_W'(idx + 1'b1);

  // State, captured arguments and registered memory-side outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      idx        <= '0;
      hold       <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      MemAddr    <= '0;
      MemWriteEn <= 1'b0;
      MemToReg   <= 1'b0;
      MemWrData  <= '0;
    end else begin
      state      <= state_d;
      src        <= src_d;
      dst        <= dst_d;
      len        <= len_d;
      idx        <= idx_d;
      hold       <= hold_d;
      Busy       <= busy_d;
      Done       <= done_d;
      MemAddr    <= addr_d;
      MemWriteEn <= we_d;
      MemToReg   <= to_reg_d;
      MemWrData  <= wdata_d;
    end
  end

  // Next state, then outputs decoded from the next state so they register
  // into place exactly for the cycle the FSM occupies that state
  always_comb begin
    state_d  = state;
    src_d    = src;
    dst_d    = dst;
    len_d    = len;
    idx_d    = idx;
    hold_d   = hold;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    we_d     = 1'b0;
    to_reg_d = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;

    unique case (state)
      IDLE: begin
        if (Start) begin
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          len_d   = Length;
          idx_d   = '0;
          state_d = (Length != '0) ? READ : DONE;
        end
      end
      READ: begin
        hold_d  = MemRdData;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc < len) ? READ : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      READ: begin
        busy_d   = 1'b1;
        to_reg_d = 1'b1;
        addr_d   = ADDR_W'(src_d + idx_d);
      end
      WRITE: begin
        busy_d  = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_W'(dst_d + idx_d);
        wdata_d = hold_d;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural memory, directed copies, and a
// queue-based scoreboard checked by an independent negedge monitor.
module tb_mem_copy_engine;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr, DstAddr, Length;
  logic       Busy, Done;
  logic [7:0] MemAddr;
  logic       MemWriteEn, MemToReg;
  logic [7:0] MemWrData, MemRdData;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
    .Busy(Busy), .Done(Done),
    .MemAddr(MemAddr), .MemWriteEn(MemWriteEn), .MemToReg(MemToReg),
    .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        wq[$];
  int         dq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         busy_cnt = 0;
  logic       prev_we = 1'b0;

  logic [7:0] mem [256];
  logic       pre_en = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Memory: combinational read, clocked write; bench presets share the port
  assign MemRdData = mem[MemAddr];
  always @(posedge Clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (MemWriteEn) mem[MemAddr] <= MemWrData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT writes or signals Done
  always @(negedge Clk) begin
    if (Reset) begin
      if (MemWriteEn) begin
        chk("we_exclusive", {31'd0, prev_we | MemToReg}, 32'd0);
        if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", {24'd0, MemAddr}, {24'd0, e.addr});
          chk("wr_data", {24'd0, MemWrData}, {24'd0, e.data});
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      if (Done) begin
        chk("done_not_busy", {31'd0, Busy}, 32'd0);
        if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("done_cycle", cyc, dq.pop_front());
      end
      if (!Busy)
        chk("idle_outputs", {14'd0, MemAddr, MemWrData, MemWriteEn, MemToReg}, 32'd0);
      else
        busy_cnt++;
      prev_we = MemWriteEn;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic preset(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge Clk);
    pre_en = 1'b0;
  endtask

  // Call at a negedge: Start is accepted at the next rising edge (edge k)
  task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                       input logic [7:0] e [8], input int nw, input bit exp_done);
    int k;
    k = cyc + 1;
    busy_cnt = 0;
    Start = 1'b1; SrcAddr = s; DstAddr = d; Length = l;
    for (int i = 0; i < nw; i++) wq.push_back('{8'(d + 8'(i)), e[i], k + 1 + 2 * i});
    if (exp_done) dq.push_back(k + 2 * int'(l));
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (wq.size() == 0 && dq.size() == 0 && !Busy && !Done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk({name, "_timeout"}, 32'd1, 32'd0);
      wq.delete();
      dq.delete();
    end
  endtask

  task automatic check_mem(input string name, input logic [7:0] base,
                           input logic [7:0] e [8], input int n);
    for (int i = 0; i < n; i++) chk(name, {24'd0, mem[8'(base + 8'(i))]}, {24'd0, e[i]});
  endtask

  logic [7:0] e [8];

  initial begin
    Reset = 1'b1; Start = 1'b0; SrcAddr = 8'h00; DstAddr = 8'h00; Length = 8'h00;
    #1 Reset = 1'b0;
    #1;
    chk("reset_state", {14'd0, Busy, Done, MemAddr, MemWriteEn, MemToReg, MemWrData},
        32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    // Basic copy
    preset(8'h10, 8'hAA); preset(8'h11, 8'hBB); preset(8'h12, 8'hCC); preset(8'h13, 8'hDD);
    for (int i = 0; i < 4; i++) preset(8'(8'h40 + 8'(i)), 8'h00);
    e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00};
    @(negedge Clk);
    issue(8'h10, 8'h40, 8'd4, e, 4, 1'b1);
    wait_idle("basic");
    chk("basic_busy_cycles", busy_cnt, 32'd8);
    check_mem("basic_mem", 8'h40, e, 4);

    // Zero length: Done next cycle, no Busy, no writes
    @(negedge Clk);
    issue(8'h10, 8'h50, 8'd0, e, 0, 1'b1);
    wait_idle("zero");
    chk("zero_busy_cycles", busy_cnt, 32'd0);

    // Wrap past 0xFF
    preset(8'hFE, 8'h01); preset(8'hFF, 8'h02); preset(8'h00, 8'h03); preset(8'h01, 8'h04);
    e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    @(negedge Clk);
    issue(8'hFE, 8'h80, 8'd4, e, 4, 1'b1);
    wait_idle("wrap");
    check_mem("wrap_mem", 8'h80, e, 4);

    // Overlapping forward copy replicates the first word
    preset(8'h20, 8'h5A); preset(8'h21, 8'h01); preset(8'h22, 8'h02); preset(8'h23, 8'h03);
    e = '{8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    @(negedge Clk);
    issue(8'h20, 8'h21, 8'd3, e, 3, 1'b1);
    wait_idle("overlap");
    check_mem("overlap_mem", 8'h21, e, 3);

    // Start while busy is ignored
    preset(8'h30, 8'h71); preset(8'h31, 8'h72); preset(8'h90, 8'h00);
    e = '{8'h71, 8'h72, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    @(negedge Clk);
    issue(8'h30, 8'h38, 8'd2, e, 2, 1'b1);
    Start = 1'b1; SrcAddr = 8'h10; DstAddr = 8'h90; Length = 8'd4;
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    wait_idle("busy_start");
    check_mem("busy_start_mem", 8'h38, e, 2);
    chk("busy_start_dst2", {24'd0, mem[8'h90]}, 32'd0);

    // Reset after the third write of an 8-word copy
    for (int i = 0; i < 8; i++) preset(8'(8'h50 + 8'(i)), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 8; i++) preset(8'(8'h60 + 8'(i)), 8'h00);
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    @(negedge Clk);
    issue(8'h50, 8'h60, 8'd8, e, 3, 1'b0);
    repeat (6) @(negedge Clk);
    #1 Reset = 1'b0;
    #1;
    chk("abort_outputs", {14'd0, Busy, Done, MemAddr, MemWriteEn, MemToReg, MemWrData},
        32'd0);
    chk("abort_pending_writes", wq.size(), 32'd0);
    repeat (3) @(negedge Clk);
    check_mem("abort_written", 8'h60, e, 3);
    for (int i = 3; i < 8; i++) chk("abort_untouched", {24'd0, mem[8'(8'h60 + 8'(i))]}, 32'd0);
    // Release and start on the same cycle: accepted at the first edge with Reset high
    Reset = 1'b1;
    issue(8'h50, 8'h60, 8'd8, e, 8, 1'b1);
    wait_idle("after_reset");
    chk("after_reset_busy_cycles", busy_cnt, 32'd16);
    check_mem("after_reset_mem", 8'h60, e, 8);

    repeat (3) @(negedge Clk);
    chk("leftover_writes", wq.size(), 32'd0);
    chk("leftover_dones", dq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
